// File: rtl/ch_queue_pkg.sv
// Shared helpers for the ch_queue family of FIFOs.
// Provides ceil-log2, pointer-width derivation and a parameter legality check
// so every queue variant sizes its pointers and validates its parameters the
// same way.
package ch_queue_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int unsigned data_w,
                                   input int unsigned depth,
                                   input int unsigned afull_th,
                                   input int unsigned aempty_th);
    bit ok;
    ok = 1'b1;
    if (data_w < 1) ok = 1'b0;
    if (depth < 2 || (depth & (depth - 1)) != 0) ok = 1'b0;
    if (afull_th < 1 || afull_th > depth) ok = 1'b0;
    if (aempty_th > depth - 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/ch_queue_ram.sv
// Storage array for ch_queue variants: DATA_W x DEPTH, one synchronous write
// port and one asynchronous read port. Contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write payload
//   raddr  : read address
//   rdata  : read payload (combinational)
module ch_queue_ram
  import ch_queue_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ch_queue_flow.sv
// Parametrised ready/valid FIFO with synchronous flush, almost-full/empty
// flags and an optional zero-latency bypass when empty (FLOW=1).
//   clk, reset        : clock, synchronous active-high reset (zeroes pointers)
//   io_flush          : discard all entries next cycle
//   io_enq_*          : producer handshake and payload
//   io_deq_*          : consumer handshake and head payload
//   io_size           : occupancy 0..DEPTH
//   io_almost_full    : size >= AFULL_TH
//   io_almost_empty   : size <= AEMPTY_TH
module ch_queue_flow
  import ch_queue_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_TH  = 3,
  parameter int unsigned AEMPTY_TH = 1,
  parameter bit          FLOW      = 1'b0,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned PTR_W    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_flush,
  input  logic              io_enq_valid,
  input  logic [DATA_W-1:0] io_enq_data,
  output logic              io_enq_ready,
  output logic              io_deq_valid,
  output logic [DATA_W-1:0] io_deq_data,
  input  logic              io_deq_ready,
  output logic [AW:0]       io_size,
  output logic              io_almost_full,
  output logic              io_almost_empty
);

  if (!params_ok(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("ch_queue_flow: illegal DATA_W/DEPTH/AFULL_TH/AEMPTY_TH");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty;
  logic              enq_fire, deq_fire, bypass;
  logic              wr_en, rd_adv;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign io_enq_ready = !full && !io_flush && !reset;
  assign io_deq_valid = (!empty || (FLOW && io_enq_valid)) && !io_flush && !reset;
  assign io_deq_data  = (FLOW && empty) ? io_enq_data : rd_data;

  assign enq_fire = io_enq_valid && io_enq_ready;
  assign deq_fire = io_deq_valid && io_deq_ready;

  // Empty-queue bypass: the payload goes straight through, nothing is stored.
  assign bypass = FLOW && empty && enq_fire && deq_fire;
  assign wr_en  = enq_fire && !bypass;
  assign rd_adv = deq_fire && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (io_flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  ch_queue_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(io_enq_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );

  assign io_size         = wr_ptr - rd_ptr;
  assign io_almost_full  = (io_size >= PTR_W'(AFULL_TH));
  assign io_almost_empty = (io_size <= PTR_W'(AEMPTY_TH));

endmodule

// File: tb/tb_ch_queue_flow.sv
module tb_ch_queue_flow;

  logic       clk = 1'b0;
  logic       reset, io_flush, io_enq_valid, io_deq_ready;
  logic [7:0] io_enq_data;

  logic       er0, dv0, af0, ae0, er1, dv1, af1, ae1;
  logic [7:0] dd0, dd1;
  logic [2:0] sz0, sz1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ch_queue_flow #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FLOW(1'b0)) u0 (
    .clk(clk), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_data(io_enq_data), .io_enq_ready(er0),
    .io_deq_valid(dv0), .io_deq_data(dd0), .io_deq_ready(io_deq_ready),
    .io_size(sz0), .io_almost_full(af0), .io_almost_empty(ae0)
  );

  ch_queue_flow #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1), .FLOW(1'b1)) u1 (
    .clk(clk), .reset(reset), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_data(io_enq_data), .io_enq_ready(er1),
    .io_deq_valid(dv1), .io_deq_data(dd1), .io_deq_ready(io_deq_ready),
    .io_size(sz1), .io_almost_full(af1), .io_almost_empty(ae1)
  );

  typedef struct {
    logic       flush;
    logic       ev;
    logic [7:0] d;
    logic       dr;
    logic       er;
    logic       dv;
    logic       chkd;
    logic [7:0] dd;
    logic [2:0] sz;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic flush, logic ev, logic [7:0] d, logic dr,
                              logic er, logic dv, logic chkd, logic [7:0] dd,
                              logic [2:0] sz, logic af, logic ae);
    vec_t v;
    v.flush = flush; v.ev = ev; v.d = d; v.dr = dr;
    v.er = er; v.dv = dv; v.chkd = chkd; v.dd = dd;
    v.sz = sz; v.af = af; v.ae = ae;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic ev,
                       input logic [7:0] d, input logic dr);
    @(negedge clk);
    reset = rst; io_flush = fl; io_enq_valid = ev; io_enq_data = d; io_deq_ready = dr;
    #1;
  endtask

  initial begin
    reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_data = '0; io_deq_ready = 1'b0;

    // Filling, full, draining.
    //                 fl  ev  d      dr  er  dv  chk dd     sz  af  ae
    tbl.push_back(mk(0, 1, 8'h11, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h22, 0, 1, 1, 1, 8'h11, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'h33, 0, 1, 1, 1, 8'h11, 2, 0, 0));
    tbl.push_back(mk(0, 1, 8'h44, 0, 1, 1, 1, 8'h11, 3, 1, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, 1, 1, 8'h11, 4, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1, 8'h11, 4, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h22, 3, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h33, 2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'h44, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    // Prefill to size 2, then stream across pointer wrap.
    tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h01, 0, 1, 1, 1, 8'h00, 1, 0, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 1, 8'(i + 2), 1, 1, 1, 1, 8'(i), 2, 0, 0));
    // Grow to size 3, flush with a competing enqueue, confirm 0xAA dropped.
    tbl.push_back(mk(0, 1, 8'h0C, 0, 1, 1, 1, 8'h0A, 2, 0, 0));
    tbl.push_back(mk(1, 1, 8'hAA, 1, 0, 0, 0, 8'h00, 3, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hBB, 0, 1, 0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hBB, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1));

    // Reset state.
    drive(1, 0, 1, 8'h99, 1);
    chk("rst_enq_ready0", 32'(er0), 0);
    chk("rst_deq_valid0", 32'(dv0), 0);
    chk("rst_deq_valid1", 32'(dv1), 0);
    drive(0, 0, 0, 8'h00, 0);
    chk("post_rst_size", 32'(sz0), 0);
    chk("post_rst_enq_ready", 32'(er0), 1);
    chk("post_rst_deq_valid", 32'(dv0), 0);
    chk("post_rst_afull", 32'(af0), 0);
    chk("post_rst_aempty", 32'(ae0), 1);

    // FLOW=0 table.
    foreach (tbl[i]) begin
      drive(0, tbl[i].flush, tbl[i].ev, tbl[i].d, tbl[i].dr);
      chk($sformatf("v%0d enq_ready", i), 32'(er0), 32'(tbl[i].er));
      chk($sformatf("v%0d deq_valid", i), 32'(dv0), 32'(tbl[i].dv));
      chk($sformatf("v%0d size", i), 32'(sz0), 32'(tbl[i].sz));
      chk($sformatf("v%0d afull", i), 32'(af0), 32'(tbl[i].af));
      chk($sformatf("v%0d aempty", i), 32'(ae0), 32'(tbl[i].ae));
      if (tbl[i].chkd)
        chk($sformatf("v%0d deq_data", i), 32'(dd0), 32'(tbl[i].dd));
    end

    // Bypass on FLOW=1; FLOW=0 shows one-cycle latency on the same stimulus.
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 8'h5A, 1);
    chk("byp_deq_valid1", 32'(dv1), 1);
    chk("byp_deq_data1", 32'(dd1), 32'h5A);
    chk("byp_size1", 32'(sz1), 0);
    chk("byp_enq_ready1", 32'(er1), 1);
    chk("lat_deq_valid0", 32'(dv0), 0);
    drive(0, 0, 1, 8'h5A, 0);
    chk("byp_after_size1", 32'(sz1), 0);
    chk("byp_hold_valid1", 32'(dv1), 1);
    chk("byp_hold_data1", 32'(dd1), 32'h5A);
    chk("lat_size0", 32'(sz0), 1);
    chk("lat_deq_valid0b", 32'(dv0), 1);
    chk("lat_deq_data0", 32'(dd0), 32'h5A);
    drive(0, 0, 0, 8'h00, 0);
    chk("stored_size1", 32'(sz1), 1);
    chk("stored_valid1", 32'(dv1), 1);
    chk("stored_data1", 32'(dd1), 32'h5A);
    chk("mid_size0", 32'(sz0), 2);

    // Reset mid-stream at size 2.
    drive(1, 0, 1, 8'h77, 1);
    chk("mid_rst_enq_ready0", 32'(er0), 0);
    chk("mid_rst_deq_valid0", 32'(dv0), 0);
    chk("mid_rst_enq_ready1", 32'(er1), 0);
    chk("mid_rst_deq_valid1", 32'(dv1), 0);
    drive(0, 0, 0, 8'h00, 1);
    chk("after_rst_size0", 32'(sz0), 0);
    chk("after_rst_enq_ready0", 32'(er0), 1);
    chk("after_rst_deq_valid0", 32'(dv0), 0);
    chk("after_rst_aempty0", 32'(ae0), 1);
    chk("after_rst_size1", 32'(sz1), 0);
    chk("after_rst_deq_valid1", 32'(dv1), 0);
    drive(0, 0, 0, 8'h00, 1);
    chk("no_stale_valid0", 32'(dv0), 0);
    chk("no_stale_size0", 32'(sz0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ch_queue_flow.md
Name: ch_queue_flow

Overview:
Parametrised ready/valid FIFO. It succeeds the fixed 4-bit, depth-2 ch_queue and is generalised in data width and depth. New features over that block:
- synchronous flush
- almost-full / almost-empty flags
- optional same-cycle bypass ("flow") mode for the empty case
- explicit pointer reset

It sits between producer and consumer pipeline stages and is used wherever the design needs elastic buffering.

Parameters:
DATA_W, 8, payload width in bits (>=1)
DEPTH, 4, entry count; power of two, >=2
AFULL_TH, 3, io_almost_full asserted when size >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 1, io_almost_empty asserted when size <= AEMPTY_TH (0..DEPTH-1)
FLOW, 0, 1 = empty-queue bypass enabled; 0 = registered-only path

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
io_flush  in  1  synchronous discard of all entries
io_enq_valid  in  1  producer has data
io_enq_data  in  DATA_W  producer payload
io_enq_ready  out  1  queue accepts this cycle
io_deq_valid  out  1  queue presents data
io_deq_data  out  DATA_W  head payload
io_deq_ready  in  1  consumer accepts
io_size  out  AW+1  occupancy 0..DEPTH; AW = log2(DEPTH)
io_almost_full  out  1  occupancy threshold flag
io_almost_empty  out  1  occupancy threshold flag

Behaviour:
- Pointers:
  - wr_ptr, rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - full = (addr bits equal) & (wrap bits differ); empty = pointers equal.
  - size = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Handshake signals:
  - enq_fire = io_enq_valid & io_enq_ready; deq_fire = io_deq_valid & io_deq_ready.
  - io_enq_ready = !full & !io_flush & !reset. It has no combinational dependence on io_deq_ready, so a full queue never accepts, even when a dequeue happens in the same cycle.
  - io_deq_valid = (!empty | (FLOW & io_enq_valid)) & !io_flush & !reset.
  - io_deq_data = mem[rd_ptr addr bits] when !empty; io_enq_data when empty and FLOW=1; value is don't-care when io_deq_valid=0.
- Non-bypass updates:
  - enq_fire writes mem[wr addr] and increments wr_ptr.
  - deq_fire with !empty increments rd_ptr.
  - Simultaneous enq_fire and deq_fire leave size unchanged; both pointers advance.
- FLOW=1 and empty:
  - If enq_fire & deq_fire, the payload bypasses with zero latency: no memory write, no pointer change, size stays 0.
  - If enq_fire & !io_deq_ready, normal write; deq_valid stays high next cycle with the same data.
- Latency:
  - FLOW=0: data enqueued in cycle N is first visible at deq in cycle N+1.
  - FLOW=1: visible in cycle N when the queue is empty.
- Wrap-around: the address wraps modulo DEPTH; the wrap bit toggles. Full and empty must be distinguished across every wrap.
- Flush (io_flush=1):
  - In that cycle no fire occurs, since both handshakes are forced low.
  - Next cycle: rd_ptr <= wr_ptr, so the queue is empty and memory contents are ignored.
  - Flush takes priority over all enqueue/dequeue activity.
- Reset (reset=1):
  - Next cycle: wr_ptr = rd_ptr = 0.
  - During reset: io_enq_ready=0, io_deq_valid=0.
  - Post-reset outputs: io_enq_ready=1, io_deq_valid=0 (FLOW=1: follows io_enq_valid), io_size=0, io_almost_full=(AFULL_TH==0 ? 1 : 0) (always 0 under the legal range), io_almost_empty=1.
  - Reset mid-operation discards contents exactly as flush does, and also zeroes the pointers.
  - Memory array is not reset.
- Flags: io_almost_full = (size >= AFULL_TH); io_almost_empty = (size <= AEMPTY_TH). Both are combinational from the registered pointers, so they are glitch-free per cycle and unaffected by bypass.
- Parameter checks: elaboration-time error if DEPTH is not a power of two, or if AFULL_TH or AEMPTY_TH is out of range.

Decomposition:
- Shared package ch_queue_pkg: clog2 function; pointer-width constant derivation (AW, PTR_W); parameter-legality check macro/function. It is reused by future queue variants.
- Sub-module ch_queue_ram: DATA_W x DEPTH storage, one synchronous write port, one asynchronous read port, no reset.
- Pointer/flag/bypass logic stays in ch_queue_flow.

Test Plan:
1. DATA_W=8, DEPTH=4, FLOW=0; reset, then enq 0x11,0x22,0x33,0x44 with deq_ready=0 -> io_size 1,2,3,4; almost_full rises at size 3; enq_ready=0 at size 4. A 5th enq held valid is not accepted.
2. From full, deq_ready=1 for 4 cycles -> deq_data 0x11,0x22,0x33,0x44 in order; size 3,2,1,0; almost_empty high at size<=1; deq_valid=0 after.
3. Wrap stress: 10 cycles of enq_valid=1 and deq_ready=1 at steady size 2, with data 0..9 -> output sequence 0..9 in order, no loss or duplication across pointer wrap, size stays 2.
4. Flush at size 3 with enq_valid=1 in the same cycle -> enq_ready=0 and deq_valid=0 that cycle; next cycle size=0, deq_valid=0; enqueued data 0xAA not stored.
5. FLOW=1, empty, enq_valid=1 with data 0x5A, deq_ready=1 -> deq_valid=1, deq_data=0x5A same cycle, size stays 0. Repeat with deq_ready=0 -> size 1 next cycle, deq_data still 0x5A.
6. Reset asserted mid-stream at size 2 for 1 cycle -> handshakes low during reset; after reset size=0, enq_ready=1, deq_valid=0, and old entries are never emitted.
